// File: rtl/order_book_side.sv
// One side (bid or ask) of a price-level book driven by incremental
// New/Change/Delete/Clear entries. Each accepted entry is held, applied to
// the level array in one cycle, then announced with a one-cycle strobe.
module order_book_side #(
    parameter int unsigned        DEPTH      = 10,
    parameter int unsigned        LVL_W      = 4,
    parameter int unsigned        ENTRY_W    = 88,
    parameter logic [ENTRY_W-1:0] NULL_LEVEL = ENTRY_W'(1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       msg_valid,
    output logic                       msg_ready,
    input  logic [1:0]                 msg_action,
    input  logic [LVL_W-1:0]           msg_level,
    input  logic [15:0]                msg_qty,
    input  logic [7:0]                 msg_norders,
    input  logic [63:0]                msg_price,
    output logic [DEPTH*ENTRY_W-1:0]   levels_out,
    output logic [LVL_W-1:0]           depth_count,
    output logic                       book_update,
    output logic                       msg_err
);

    localparam logic [1:0] ACT_NEW    = 2'd0;
    localparam logic [1:0] ACT_CHANGE = 2'd1;
    localparam logic [1:0] ACT_DELETE = 2'd2;
    localparam logic [1:0] ACT_CLEAR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic                 capture_c;
    logic                 apply_c;

    logic [1:0]           hold_action;
    logic [LVL_W-1:0]     hold_level;
    logic [ENTRY_W-1:0]   hold_entry;

    logic [ENTRY_W-1:0]   lvl_q [DEPTH];
    logic [ENTRY_W-1:0]   lvl_nxt_c [DEPTH];
    logic [LVL_W-1:0]     depth_q;
    logic [LVL_W-1:0]     depth_nxt_c;
    logic                 entry_ok_c;

    int unsigned          lvl_u;
    int unsigned          cnt_u;
    int unsigned          idx_u;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and sequencing controls
    always_comb begin
        state_d   = state_q;
        capture_c = 1'b0;
        apply_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (msg_valid) begin
                    capture_c = 1'b1;
                    state_d   = S_APPLY;
                end
            end
            S_APPLY: begin
                apply_c = 1'b1;
                state_d = S_PUBLISH;
            end
            S_PUBLISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign msg_ready = (state_q == S_IDLE);

    // Holding registers for the accepted entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_action <= 2'd0;
            hold_level  <= '0;
            hold_entry  <= '0;
        end else if (capture_c) begin
            hold_action <= msg_action;
            hold_level  <= msg_level;
            hold_entry  <= ENTRY_W'({msg_qty, msg_norders, msg_price});
        end
    end

    // Validate the held entry against the current occupancy
    always_comb begin
        lvl_u      = 32'(hold_level);
        cnt_u      = 32'(depth_q);
        idx_u      = lvl_u - 32'd1;
        entry_ok_c = 1'b0;
        case (hold_action)
            ACT_NEW:    entry_ok_c = (lvl_u >= 32'd1) && (lvl_u <= cnt_u + 32'd1) && (lvl_u <= DEPTH);
            ACT_CHANGE: entry_ok_c = (lvl_u >= 32'd1) && (lvl_u <= cnt_u);
            ACT_DELETE: entry_ok_c = (lvl_u >= 32'd1) && (lvl_u <= cnt_u);
            default:    entry_ok_c = 1'b1;
        endcase
    end

    // Candidate array and count after applying the held entry
    always_comb begin
        lvl_nxt_c   = lvl_q;
        depth_nxt_c = depth_q;
        case (hold_action)
            ACT_NEW: begin
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    if (i > idx_u) begin
                        lvl_nxt_c[i] = lvl_q[i-1];
                    end
                end
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (i == idx_u) begin
                        lvl_nxt_c[i] = hold_entry;
                    end
                end
                if (cnt_u < DEPTH) begin
                    depth_nxt_c = depth_q + LVL_W'(1);
                end
            end
            ACT_CHANGE: begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (i == idx_u) begin
                        lvl_nxt_c[i] = hold_entry;
                    end
                end
            end
            ACT_DELETE: begin
                for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                    if (i >= idx_u) begin
                        lvl_nxt_c[i] = lvl_q[i+1];
                    end
                end
                lvl_nxt_c[DEPTH-1] = NULL_LEVEL;
                depth_nxt_c        = depth_q - LVL_W'(1);
            end
            default: begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    lvl_nxt_c[i] = NULL_LEVEL;
                end
                depth_nxt_c = '0;
            end
        endcase
    end

    // Book storage: commit only accepted entries
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                lvl_q[i] <= NULL_LEVEL;
            end
            depth_q <= '0;
        end else if (apply_c && entry_ok_c) begin
            lvl_q   <= lvl_nxt_c;
            depth_q <= depth_nxt_c;
        end
    end

    // Outcome strobes, high for the single PUBLISH cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            book_update <= 1'b0;
            msg_err     <= 1'b0;
        end else begin
            book_update <= apply_c & entry_ok_c;
            msg_err     <= apply_c & ~entry_ok_c;
        end
    end

    // Flatten the level array, best level in the low slice
    always_comb begin
        levels_out = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            levels_out[i*ENTRY_W +: ENTRY_W] = lvl_q[i];
        end
    end

    assign depth_count = depth_q;

endmodule

// File: tb/tb_order_book_side.sv
// Bench for order_book_side: directed vector table, reset/busy sequences and
// randomized entries compared against a queue-based book model.
module tb_order_book_side;

    localparam int unsigned DEPTH   = 10;
    localparam int unsigned LVL_W   = 4;
    localparam int unsigned ENTRY_W = 88;
    localparam int unsigned BOOK_W  = DEPTH * ENTRY_W;
    localparam logic [ENTRY_W-1:0] NULL_E = ENTRY_W'(1);

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               msg_valid = 1'b0;
    logic               msg_ready;
    logic [1:0]         msg_action = 2'd0;
    logic [LVL_W-1:0]   msg_level = '0;
    logic [15:0]        msg_qty = '0;
    logic [7:0]         msg_norders = '0;
    logic [63:0]        msg_price = '0;
    logic [BOOK_W-1:0]  levels_out;
    logic [LVL_W-1:0]   depth_count;
    logic               book_update;
    logic               msg_err;

    int errors = 0;
    int checks = 0;

    order_book_side #(
        .DEPTH(DEPTH), .LVL_W(LVL_W), .ENTRY_W(ENTRY_W), .NULL_LEVEL(NULL_E)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_action(msg_action), .msg_level(msg_level),
        .msg_qty(msg_qty), .msg_norders(msg_norders), .msg_price(msg_price),
        .levels_out(levels_out), .depth_count(depth_count),
        .book_update(book_update), .msg_err(msg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference book: queue, index 0 = best level
    logic [ENTRY_W-1:0] book[$];

    function automatic bit model_apply(input logic [1:0] a, input int l, input logic [ENTRY_W-1:0] e);
        int c;
        c = book.size();
        case (a)
            2'd0: if (l >= 1 && l <= c + 1 && l <= int'(DEPTH)) begin
                book.insert(l - 1, e);
                if (book.size() > int'(DEPTH)) void'(book.pop_back());
                return 1'b1;
            end
            2'd1: if (l >= 1 && l <= c) begin
                book[l-1] = e;
                return 1'b1;
            end
            2'd2: if (l >= 1 && l <= c) begin
                book.delete(l - 1);
                return 1'b1;
            end
            default: begin
                book.delete();
                return 1'b1;
            end
        endcase
        return 1'b0;
    endfunction

    function automatic logic [BOOK_W-1:0] model_pack();
        logic [BOOK_W-1:0] r;
        r = '0;
        for (int k = 0; k < int'(DEPTH); k++)
            r[k*ENTRY_W +: ENTRY_W] = (k < book.size()) ? book[k] : NULL_E;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_book(input string name);
        logic [BOOK_W-1:0] e;
        int bad;
        e = model_pack();
        checks++;
        if (levels_out !== e) begin
            errors++;
            bad = 0;
            for (int k = DEPTH - 1; k >= 0; k--)
                if (levels_out[k*ENTRY_W +: ENTRY_W] !== e[k*ENTRY_W +: ENTRY_W]) bad = k;
            $display("FAIL %s: level %0d got %h expected %h", name, bad + 1,
                     levels_out[bad*ENTRY_W +: ENTRY_W], e[bad*ENTRY_W +: ENTRY_W]);
        end
    endtask

    // Present one entry, then check the full 3-cycle handshake and result
    task automatic send(input logic [1:0] a, input logic [3:0] l, input logic [15:0] q,
                        input logic [7:0] n, input logic [63:0] p,
                        input logic exp_err, input logic [3:0] exp_cnt, input string tag);
        int w;
        w = 0;
        @(negedge clk);
        while (!msg_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, " ready_wait"}, 64'(msg_ready), 64'd1);
        msg_action = a; msg_level = l; msg_qty = q; msg_norders = n; msg_price = p;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        check({tag, " ready_apply"}, 64'(msg_ready), 64'd0);
        check({tag, " strobes_apply"}, 64'({book_update, msg_err}), 64'd0);
        @(posedge clk); #1;
        check({tag, " ready_publish"}, 64'(msg_ready), 64'd0);
        check({tag, " book_update"}, 64'(book_update), 64'(!exp_err));
        check({tag, " msg_err"}, 64'(msg_err), 64'(exp_err));
        check({tag, " depth_count"}, 64'(depth_count), 64'(exp_cnt));
        check_book({tag, " levels"});
        @(posedge clk); #1;
        check({tag, " strobes_idle"}, 64'({book_update, msg_err}), 64'd0);
        check({tag, " ready_idle"}, 64'(msg_ready), 64'd1);
    endtask

    typedef struct {
        logic [1:0]  act;
        logic [3:0]  lvl;
        logic [15:0] qty;
        logic [7:0]  nord;
        logic [63:0] price;
        logic        exp_err;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [1:0] a, input logic [3:0] l, input logic [15:0] q,
                                input logic [7:0] n, input logic [63:0] p,
                                input logic ee, input logic [3:0] ec);
        vec_t v;
        v.act = a; v.lvl = l; v.qty = q; v.nord = n; v.price = p;
        v.exp_err = ee; v.exp_cnt = ec;
        vecs.push_back(v);
    endfunction

    initial begin
        vec_t v;
        bit ok;
        int pulses, errs;
        logic [1:0] ra;
        logic [3:0] rl;
        logic [15:0] rq;
        logic [7:0] rn;
        logic [63:0] rp;

        // Directed table: error/count expectations are hand-derived
        add(0, 1, 100, 3, 64'd5000, 0, 1);
        add(3, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 64'd10, 0, 1);
        add(0, 1, 2, 1, 64'd20, 0, 2);
        add(0, 1, 3, 1, 64'd30, 0, 3);
        add(2, 2, 0, 0, 0, 0, 2);
        add(1, 2, 7, 1, 64'd10, 0, 2);
        add(0, 4, 9, 9, 64'd99, 1, 2);
        add(1, 3, 9, 9, 64'd99, 1, 2);
        add(2, 0, 0, 0, 0, 1, 2);
        add(0, 11, 9, 9, 64'd99, 1, 2);
        add(0, 0, 9, 9, 64'd99, 1, 2);
        add(0, 3, 4, 2, 64'd5, 0, 3);
        add(3, 5, 0, 0, 0, 0, 0);
        add(3, 0, 0, 0, 0, 0, 0);
        add(2, 1, 0, 0, 0, 1, 0);
        add(1, 1, 1, 1, 64'd1, 1, 0);
        for (int i = 1; i <= 10; i++)
            add(0, 1, 16'(i * 10), 8'(i), 64'(i), 0, 4'(i));
        add(0, 1, 110, 11, 64'd11, 0, 10);
        add(0, 11, 1, 1, 64'd12, 1, 10);
        add(2, 10, 0, 0, 0, 0, 9);
        add(0, 10, 5, 5, 64'hFFFF_FFFF_FFFF_FF9D, 0, 10);
        add(1, 10, 6, 6, 64'd99, 0, 10);
        add(2, 1, 0, 0, 0, 0, 9);
        add(0, 1, 1, 1, 64'd1, 0, 10);
        add(3, 0, 0, 0, 0, 0, 0);

        // Reset state
        #23;
        check("reset depth_count", 64'(depth_count), 64'd0);
        check("reset strobes", 64'({book_update, msg_err}), 64'd0);
        check_book("reset levels");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("reset msg_ready", 64'(msg_ready), 64'd1);

        foreach (vecs[i]) begin
            v = vecs[i];
            ok = model_apply(v.act, int'(v.lvl), {v.qty, v.nord, v.price});
            send(v.act, v.lvl, v.qty, v.nord, v.price, v.exp_err, v.exp_cnt,
                 $sformatf("vec%0d", i));
        end

        // Reset asserted during APPLY aborts the entry and empties the book
        ok = model_apply(0, 1, {16'd5, 8'd1, 64'd500});
        send(0, 1, 5, 1, 64'd500, 0, 1, "pre_reset");
        @(negedge clk);
        msg_action = 0; msg_level = 1; msg_qty = 8; msg_norders = 2; msg_price = 64'd800;
        msg_valid = 1'b1;
        @(posedge clk); #1;
        msg_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        book.delete();
        #1;
        check("abort depth_count", 64'(depth_count), 64'd0);
        check_book("abort levels");
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            pulses += int'(book_update) + int'(msg_err);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        pulses += int'(book_update) + int'(msg_err);
        check("abort strobes", 64'(pulses), 64'd0);
        check("abort msg_ready", 64'(msg_ready), 64'd1);

        // msg_valid held through busy cycles is taken only once
        @(negedge clk);
        msg_action = 0; msg_level = 1; msg_qty = 77; msg_norders = 7; msg_price = 64'd77;
        msg_valid = 1'b1;
        pulses = 0;
        errs = 0;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk); #1;
            pulses += int'(book_update);
            errs += int'(msg_err);
            if (c == 2) msg_valid = 1'b0;
        end
        ok = model_apply(0, 1, {16'd77, 8'd7, 64'd77});
        check("held_valid updates", 64'(pulses), 64'd1);
        check("held_valid errs", 64'(errs), 64'd0);
        check("held_valid depth", 64'(depth_count), 64'd1);
        check_book("held_valid levels");

        // Randomized entries against the reference model
        for (int i = 0; i < 400; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            ra = (r < 45) ? 2'd0 : (r < 65) ? 2'd1 : (r < 94) ? 2'd2 : 2'd3;
            rl = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                             : 4'($urandom_range(1, 11));
            rq = 16'($urandom);
            rn = 8'($urandom);
            rp = {32'($urandom), 32'($urandom)};
            ok = model_apply(ra, int'(rl), {rq, rn, rp});
            send(ra, rl, rq, rn, rp, !ok, 4'(book.size()), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
